// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and the data stage.
// Data has priority; a fairness counter forces a fetch grant after FAIR_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int FAIR_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int FAIR_W = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [FAIR_W-1:0]   fair_cnt_q, fair_cnt_d;
    logic                cancel_q, cancel_d;
    logic                grant_fetch, grant_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_FETCH;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            lat_cnt_q   <= '0;
            fair_cnt_q  <= '0;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            lat_cnt_q   <= lat_cnt_d;
            fair_cnt_q  <= fair_cnt_d;
            cancel_q    <= cancel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        lat_cnt_d   = lat_cnt_q;
        fair_cnt_d  = fair_cnt_q;
        cancel_d    = cancel_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req && (fair_cnt_q == FAIR_W'(FAIR_MAX))) begin
                    grant_fetch = 1'b1;
                end else if (d_req) begin
                    grant_data = 1'b1;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                end
            end
            S_ISSUE: begin
                lat_cnt_d = LAT_W'(MEM_LAT - 1);
                state_d   = S_WAIT;
                if (flush && (owner_q == OWN_FETCH)) begin
                    cancel_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush && (owner_q == OWN_FETCH)) begin
                    cancel_d = 1'b1;
                end
                // A flush in the capture cycle itself must already block the fetch update.
                if (lat_cnt_q == '0) begin
                    state_d = S_DONE;
                    if ((owner_q == OWN_DATA) && !we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    if ((owner_q == OWN_FETCH) && !cancel_d) begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_DONE: begin
                cancel_d = 1'b0;
                state_d  = S_IDLE;
                if ((owner_q == OWN_DATA) && if_req) begin
                    grant_fetch = 1'b1;
                end else if ((owner_q == OWN_FETCH) && d_req) begin
                    grant_data = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant_fetch) begin
            state_d    = S_ISSUE;
            owner_d    = OWN_FETCH;
            we_d       = 1'b0;
            mem_addr_d = if_addr;
            fair_cnt_d = '0;
        end else if (grant_data) begin
            state_d     = S_ISSUE;
            owner_d     = OWN_DATA;
            we_d        = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!if_req) begin
                fair_cnt_d = '0;
            end else if (fair_cnt_q != FAIR_W'(FAIR_MAX)) begin
                fair_cnt_d = fair_cnt_q + FAIR_W'(1);
            end
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = (state_q == S_DONE) && (owner_q == OWN_FETCH) && !cancel_q;
    assign d_ready   = (state_q == S_DONE) && (owner_q == OWN_DATA);
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance for most scenarios and a
// MEM_LAT=1 instance for the short-latency load; each memory model drives data only in its valid cycle.
module tb_mem_port_arbiter;

    localparam logic [31:0] GARB = 32'hBAD0_BAD0;

    logic        clk;
    logic        reset;
    int          n_checks;
    int          n_fail;

    logic        if_req, flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata, resp_a;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, stall_if, stall_mem, mem_en, mem_we;
    int          pend_a;

    logic        b_if_req, b_flush, b_d_req, b_d_we;
    logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata, b_resp;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ready, b_d_ready, b_stall_if, b_stall_mem, b_mem_en, b_mem_we;
    int          b_pend;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .FAIR_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FAIR_MAX(4)) dut_lat1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .flush(b_flush),
        .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: read data is valid only in the cycle MEM_LAT after the issue cycle.
    always @(negedge clk) begin
        mem_rdata <= (pend_a == 1) ? resp_a : GARB;
        if (mem_en) pend_a <= 2;
        else if (pend_a > 0) pend_a <= pend_a - 1;
    end

    always @(negedge clk) begin
        b_mem_rdata <= (b_pend == 1) ? b_resp : GARB;
        if (b_mem_en) b_pend <= 1;
        else if (b_pend > 0) b_pend <= b_pend - 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready got=%b exp=0", if_ready); end
        n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_d_ready got=%b exp=0", d_ready); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    endtask

    task automatic test_lone_fetch();
        resp_a  = 32'h2008_0005;
        if_addr = 32'h0040_0000;
        if_req  = 1'b1;
        #1;
        n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL t1_stall_c0 got=%b exp=1", stall_if); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL t1_mem_en_c0 got=%b exp=0", mem_en); end
        step();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL t1_mem_en_c1 got=%b exp=1", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL t1_mem_we_c1 got=%b exp=0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL t1_mem_addr got=%h exp=00400000", mem_addr); end
        n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL t1_stall_c1 got=%b exp=1", stall_if); end
        step();
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL t1_mem_en_c2 got=%b exp=0", mem_en); end
        n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL t1_stall_c2 got=%b exp=1", stall_if); end
        step();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL t1_if_ready_c3 got=%b exp=0", if_ready); end
        n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL t1_stall_c3 got=%b exp=1", stall_if); end
        step();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL t1_if_ready_c4 got=%b exp=1", if_ready); end
        n_checks++; if (if_rdata !== 32'h2008_0005) begin n_fail++; $display("FAIL t1_if_rdata got=%h exp=20080005", if_rdata); end
        n_checks++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL t1_stall_c4 got=%b exp=0", stall_if); end
        if_req = 1'b0;
        step();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL t1_if_ready_c5 got=%b exp=0", if_ready); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL t1_mem_en_c5 got=%b exp=0", mem_en); end
    endtask

    task automatic test_data_priority();
        resp_a  = 32'h8C09_0000;
        if_addr = 32'h0040_0004;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0010;
        d_wdata = 32'hDEAD_BEEF;
        if_req  = 1'b1;
        d_req   = 1'b1;
        #1;
        n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL t2_stall_mem_c0 got=%b exp=1", stall_mem); end
        step();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL t2_mem_en_c1 got=%b exp=1", mem_en); end
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL t2_mem_we_c1 got=%b exp=1", mem_we); end
        n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL t2_mem_addr_c1 got=%h exp=00000010", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t2_mem_wdata got=%h exp=deadbeef", mem_wdata); end
        step(); step(); step();
        n_checks++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL t2_d_ready_c4 got=%b exp=1", d_ready); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL t2_if_ready_c4 got=%b exp=0", if_ready); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL t2_store_d_rdata got=%h exp=0", d_rdata); end
        n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL t2_stall_mem_c4 got=%b exp=0", stall_mem); end
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL t2_mem_en_c5 got=%b exp=1", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL t2_mem_we_c5 got=%b exp=0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL t2_mem_addr_c5 got=%h exp=00400004", mem_addr); end
        step(); step();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL t2_if_ready_c7 got=%b exp=0", if_ready); end
        step();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL t2_if_ready_c8 got=%b exp=1", if_ready); end
        n_checks++; if (if_rdata !== 32'h8C09_0000) begin n_fail++; $display("FAIL t2_if_rdata got=%h exp=8c090000", if_rdata); end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        if_addr = 32'h0040_0008;
        d_we    = 1'b0;
        d_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_addr = 32'h100 + 32'(4 * k);
            resp_a = 32'hA000_0000 + 32'(k);
            if_req = 1'b1;
            step();
            n_checks++; if (mem_addr !== (32'h100 + 32'(4 * k))) begin n_fail++; $display("FAIL t3_data_grant%0d got=%h exp=%h", k, mem_addr, 32'h100 + 32'(4 * k)); end
            if_req = 1'b0;
            step(); step(); step();
            n_checks++; if (d_ready !== 1'b1 || d_rdata !== (32'hA000_0000 + 32'(k))) begin n_fail++; $display("FAIL t3_load%0d got=%b/%h exp=1/%h", k, d_ready, d_rdata, 32'hA000_0000 + 32'(k)); end
            step();
        end
        d_addr = 32'h200;
        resp_a = 32'h1234_5678;
        if_req = 1'b1;
        step();
        n_checks++; if (mem_addr !== 32'h0040_0008) begin n_fail++; $display("FAIL t3_fifth_is_fetch got=%h exp=00400008", mem_addr); end
        d_req = 1'b0;
        step(); step(); step();
        n_checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL t3_fetch_done got=%b/%h exp=1/12345678", if_ready, if_rdata); end
        if_req = 1'b0;
        step();
        d_addr = 32'h300;
        resp_a = 32'h0000_0300;
        d_req  = 1'b1;
        if_req = 1'b1;
        step();
        n_checks++; if (mem_addr !== 32'h300) begin n_fail++; $display("FAIL t3_fair_cleared got=%h exp=00000300", mem_addr); end
        if_req = 1'b0;
        step(); step(); step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h300) begin n_fail++; $display("FAIL t3_after_clear got=%b/%h exp=1/00000300", d_ready, d_rdata); end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_flush();
        if_addr = 32'h0040_000C;
        resp_a  = 32'hFFFF_0001;
        if_req  = 1'b1;
        step();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL t4_mem_en_c1 got=%b exp=1", mem_en); end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL t4_flushed_ready got=%b exp=0", if_ready); end
        n_checks++; if (if_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL t4_flushed_rdata got=%h exp=12345678", if_rdata); end
        n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL t4_stall_held got=%b exp=1", stall_if); end
        if_addr = 32'h0040_0010;
        resp_a  = 32'h2409_0007;
        step();
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL t4_idle_after_done got=%b exp=0", mem_en); end
        step();
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0040_0010) begin n_fail++; $display("FAIL t4_refetch_issue got=%b/%h exp=1/00400010", mem_en, mem_addr); end
        step(); step(); step();
        n_checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h2409_0007) begin n_fail++; $display("FAIL t4_refetch_done got=%b/%h exp=1/24090007", if_ready, if_rdata); end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        d_we   = 1'b0;
        d_addr = 32'h0000_0040;
        resp_a = 32'h0000_00AB;
        d_req  = 1'b1;
        step();
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL t5_issue got=%b/%h exp=1/00000040", mem_en, mem_addr); end
        step();
        #1 reset = 1'b1;
        #1;
        n_checks++; if (mem_en !== 1'b0 || d_ready !== 1'b0) begin n_fail++; $display("FAIL t5_rst_ctrl got=%b/%b exp=0/0", mem_en, d_ready); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL t5_rst_addr got=%h exp=0", mem_addr); end
        n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL t5_rst_stall got=%b exp=1", stall_mem); end
        #1 reset = 1'b0;
        step();
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL t5_reissue got=%b/%h exp=1/00000040", mem_en, mem_addr); end
        step(); step();
        n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL t5_early_ready got=%b exp=0", d_ready); end
        step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== 32'hAB) begin n_fail++; $display("FAIL t5_done got=%b/%h exp=1/000000ab", d_ready, d_rdata); end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_lat1_load();
        b_d_we   = 1'b0;
        b_d_addr = 32'h0000_0020;
        b_resp   = 32'h0000_1234;
        b_d_req  = 1'b1;
        step();
        n_checks++; if (b_mem_en !== 1'b1 || b_mem_we !== 1'b0 || b_mem_addr !== 32'h20) begin n_fail++; $display("FAIL t6_issue got=%b/%b/%h exp=1/0/00000020", b_mem_en, b_mem_we, b_mem_addr); end
        step();
        n_checks++; if (b_d_ready !== 1'b0 || b_stall_mem !== 1'b1) begin n_fail++; $display("FAIL t6_c2 got=%b/%b exp=0/1", b_d_ready, b_stall_mem); end
        step();
        n_checks++; if (b_d_ready !== 1'b1 || b_d_rdata !== 32'h1234) begin n_fail++; $display("FAIL t6_done got=%b/%h exp=1/00001234", b_d_ready, b_d_rdata); end
        n_checks++; if (b_if_ready !== 1'b0 || b_stall_if !== 1'b0 || b_if_rdata !== 32'h0 || b_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL t6_fetch_side got=%b/%b/%h/%h exp=0/0/0/0", b_if_ready, b_stall_if, b_if_rdata, b_mem_wdata); end
        b_d_req = 1'b0;
        step();
        n_checks++; if (b_d_ready !== 1'b0 || b_mem_en !== 1'b0) begin n_fail++; $display("FAIL t6_idle got=%b/%b exp=0/0", b_d_ready, b_mem_en); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pend_a   = 0;
        b_pend   = 0;
        resp_a   = GARB;
        b_resp   = GARB;
        reset    = 1'b0;
        if_req = 1'b0; flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        b_if_req = 1'b0; b_flush = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_if_addr = 32'h0; b_d_addr = 32'h0; b_d_wdata = 32'h0;
        #1 reset = 1'b1;
        step();
        test_reset();
        reset = 1'b0;
        test_lone_fetch();
        test_data_priority();
        test_fairness();
        test_flush();
        test_reset_mid_access();
        test_lat1_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
